// File: rtl/telem_pkg.sv
// Shared types and constants for the telemetry-to-FT framer.
package telem_pkg;
  localparam int PKT_W       = 88;
  localparam int FRAME_WORDS = 7;
  localparam int SEQ_W       = 8;
  localparam int ENTRY_W     = SEQ_W + PKT_W;
  localparam logic [15:0] DEFAULT_SYNC = 16'hA55A;

  typedef enum logic {IDLE, SEND} state_e;

  // Payload words 1..6 of a frame, sliced MSB-first from {seq, data}.
  function automatic logic [15:0] frame_word(input logic [ENTRY_W-1:0] entry,
                                             input logic [2:0] idx);
    logic [15:0] w;
    case (idx)
      3'd1:    w = entry[95:80];
      3'd2:    w = entry[79:64];
      3'd3:    w = entry[63:48];
      3'd4:    w = entry[47:32];
      3'd5:    w = entry[31:16];
      3'd6:    w = entry[15:0];
      default: w = 16'h0000;
    endcase
    return w;
  endfunction
endpackage

// File: rtl/telem_pkt_fifo.sv
// Single-clock packet FIFO; read data is the head entry (fall-through), popped by rd_en.
module telem_pkt_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 96
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_wr, do_rd;

  assign do_wr = wr_en && (count_q != CW'(DEPTH));
  assign do_rd = rd_en && (count_q != '0);

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign empty   = (count_q == '0);
endmodule

// File: rtl/telem_ft_framer.sv
// Buffers 88-bit telemetry packets and emits 7-word sync/seq frames on the FT ui_din port.
module telem_ft_framer
  import telem_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] SYNC_WORD  = DEFAULT_SYNC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [PKT_W-1:0] packet_data,
  input  logic             packet_valid,
  output logic [15:0]      ui_din,
  output logic [1:0]       ui_din_be,
  output logic             ui_din_valid,
  input  logic             ui_din_full,
  output logic [15:0]      drop_count,
  output logic             busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_e             state_q;
  logic [2:0]         idx_q;
  logic [15:0]        din_q;
  logic [1:0]         be_q;
  logic               vld_q;
  logic [SEQ_W-1:0]   seq_q;
  logic [15:0]        drop_q;
  logic               busy_q;
  logic [ENTRY_W-1:0] frame_q;

  logic [ENTRY_W-1:0] fifo_rdata;
  logic [CW-1:0]      fifo_count, cnt_d;
  logic               fifo_empty, fifo_full;
  logic               ing_vld, wr_en, pop, last_acc, send_d, busy_d;

  assign ing_vld   = packet_valid && enable;
  assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));
  assign wr_en     = ing_vld && !fifo_full;
  assign pop       = (state_q == IDLE) && !fifo_empty && enable;

  telem_pkt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data ({seq_q, packet_data}),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  // busy is registered, so it is computed from next-cycle FIFO occupancy and FSM state.
  always_comb begin
    cnt_d = fifo_count;
    if (wr_en && !pop)      cnt_d = fifo_count + 1'b1;
    else if (!wr_en && pop) cnt_d = fifo_count - 1'b1;
    last_acc = (state_q == SEND) && vld_q && !ui_din_full &&
               (idx_q == 3'(FRAME_WORDS - 1));
    send_d   = pop || ((state_q == SEND) && !last_acc);
    busy_d   = send_d || (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (pop) frame_q <= fifo_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      din_q   <= '0;
      be_q    <= '0;
      vld_q   <= 1'b0;
      seq_q   <= '0;
      drop_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      // Sequence advances on dropped packets too, so the host can detect gaps.
      if (ing_vld) begin
        seq_q <= seq_q + 1'b1;
        if (fifo_full) drop_q <= sat_inc16(drop_q);
      end
      busy_q <= busy_d;
      case (state_q)
        IDLE: begin
          if (pop) begin
            idx_q   <= '0;
            din_q   <= SYNC_WORD;
            be_q    <= 2'b11;
            vld_q   <= 1'b1;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (vld_q && !ui_din_full) begin
            if (idx_q == 3'(FRAME_WORDS - 1)) begin
              vld_q   <= 1'b0;
              be_q    <= 2'b00;
              state_q <= IDLE;
            end else begin
              idx_q <= idx_q + 3'd1;
              din_q <= frame_word(frame_q, idx_q + 3'd1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ui_din       = din_q;
  assign ui_din_be    = be_q;
  assign ui_din_valid = vld_q;
  assign drop_count   = drop_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_telem_ft_framer.sv
// Directed and randomized bench for telem_ft_framer with a queue-based frame reference model.
module tb_telem_ft_framer;
  import telem_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, enable, packet_valid, ui_din_full;
  logic [87:0] packet_data;
  logic [15:0] ui_din, drop_count;
  logic [1:0]  ui_din_be;
  logic        ui_din_valid, busy;

  always #5 clk = ~clk;

  telem_ft_framer #(.FIFO_DEPTH(DEPTH), .SYNC_WORD(16'hA55A)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .packet_data  (packet_data),
    .packet_valid (packet_valid),
    .ui_din       (ui_din),
    .ui_din_be    (ui_din_be),
    .ui_din_valid (ui_din_valid),
    .ui_din_full  (ui_din_full),
    .drop_count   (drop_count),
    .busy         (busy)
  );

  int checks = 0;
  int passed = 0;

  // Reference model: packets waiting, words of the frame being presented.
  logic [95:0] m_pkts[$];
  logic [15:0] m_words[$];
  logic [7:0]  m_seq;
  int          m_drops;
  logic [15:0] obs_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] exp_word(input logic [7:0] seq, input logic [87:0] d, input int k);
    logic [95:0] e;
    e = {seq, d};
    return (k == 0) ? 16'hA55A : e[95 - 16*(k-1) -: 16];
  endfunction

  task automatic model_edge(input logic pv, input logic [87:0] d, input logic en,
                            input logic full, input logic r);
    int pre;
    logic [95:0] e;
    if (r) begin
      m_pkts.delete();
      m_words.delete();
      m_seq   = 8'd0;
      m_drops = 0;
    end else begin
      pre = m_pkts.size();
      if (m_words.size() == 0) begin
        if (pre > 0 && en) begin
          e = m_pkts.pop_front();
          m_words.push_back(16'hA55A);
          for (int k = 0; k < 6; k++) m_words.push_back(e[95 - 16*k -: 16]);
        end
      end else if (!full) begin
        void'(m_words.pop_front());
      end
      if (pv && en) begin
        if (pre == DEPTH) begin
          if (m_drops < 65535) m_drops++;
        end else begin
          m_pkts.push_back({m_seq, d});
        end
        m_seq = m_seq + 8'd1;
      end
    end
  endtask

  task automatic step(input logic pv, input logic [87:0] d, input logic en,
                      input logic full, input logic r);
    rst = r; packet_valid = pv; packet_data = d; enable = en; ui_din_full = full;
    if (ui_din_valid === 1'b1 && !full && !r) obs_q.push_back(ui_din);
    @(posedge clk);
    model_edge(pv, d, en, full, r);
    #1;
    chk("valid", ui_din_valid, m_words.size() != 0);
    if (m_words.size() != 0) begin
      chk("din", ui_din, m_words[0]);
      chk("be", ui_din_be, 2'b11);
    end
    chk("drop_count", drop_count, m_drops);
    chk("busy", busy, (m_words.size() != 0) || (m_pkts.size() != 0));
  endtask

  task automatic idle(input logic full);
    step(1'b0, 88'h0, 1'b1, full, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (m_words.size() == 0 && m_pkts.size() == 0) break;
      idle(1'b0);
    end
    idle(1'b0);
    chk("drained_busy", busy, 1'b0);
  endtask

  function automatic logic [87:0] rnd88();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[87:0];
  endfunction

  initial begin
    logic [87:0] d;
    logic [15:0] exp1 [7];
    exp1 = '{16'hA55A, 16'h0001, 16'h0203, 16'h0405, 16'h0607, 16'h0809, 16'h0A0B};
    rst = 1'b1; enable = 1'b0; packet_valid = 1'b0; packet_data = '0; ui_din_full = 1'b0;

    // Reset state
    step(1'b0, 88'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 88'h0, 1'b0, 1'b0, 1'b1);
    chk("rst_din", ui_din, 16'h0);
    chk("rst_be", ui_din_be, 2'b00);
    chk("rst_valid", ui_din_valid, 1'b0);
    chk("rst_drop", drop_count, 16'h0);
    chk("rst_busy", busy, 1'b0);

    // Test 1: single packet, fixed latency and word order
    step(1'b1, 88'h0102030405060708090A0B, 1'b1, 1'b0, 1'b0);
    chk("t1_lat_valid", ui_din_valid, 1'b0);
    for (int k = 0; k < 7; k++) begin
      idle(1'b0);
      chk("t1_word", ui_din, exp1[k]);
      chk("t1_be", ui_din_be, 2'b11);
    end
    idle(1'b0);
    chk("t1_end_valid", ui_din_valid, 1'b0);
    chk("t1_drop", drop_count, 16'h0);

    // Test 2: backpressure while W3 is presented
    drain();
    obs_q.delete();
    d = rnd88();
    step(1'b1, d, 1'b1, 1'b0, 1'b0);
    repeat (4) idle(1'b0);
    for (int i = 0; i < 10; i++) begin
      idle(1'b1);
      chk("t2_hold", ui_din, exp_word(8'd1, d, 3));
    end
    drain();
    chk("t2_count", obs_q.size(), 7);
    for (int k = 0; k < 7 && k < obs_q.size(); k++) chk("t2_word", obs_q[k], exp_word(8'd1, d, k));

    // Test 3: overflow with depth 4 under backpressure
    step(1'b0, 88'h0, 1'b1, 1'b0, 1'b1);
    obs_q.delete();
    for (int i = 0; i < 10; i++) step(1'b1, rnd88(), 1'b1, 1'b1, 1'b0);
    chk("t3_drops", drop_count, 16'd5);
    drain();
    chk("t3_words", obs_q.size(), 35);
    for (int f = 0; f < 5 && obs_q.size() >= 35; f++) begin
      chk("t3_sync", obs_q[7*f], 16'hA55A);
      chk("t3_seq", obs_q[7*f+1][15:8], f);
    end
    obs_q.delete();
    step(1'b1, rnd88(), 1'b1, 1'b0, 1'b0);
    drain();
    chk("t3_next_seq", (obs_q.size() > 1) ? obs_q[1][15:8] : 16'hDEAD, 8'd10);

    // Test 4: drop counter saturation
    for (int i = 0; i < 70000; i++) step(1'b1, rnd88(), 1'b1, 1'b1, 1'b0);
    chk("t4_sat", drop_count, 16'hFFFF);

    // Test 5: reset after W3 accepted
    repeat (4) idle(1'b0);
    chk("t5_at_w4", ui_din_valid, 1'b1);
    step(1'b0, 88'h0, 1'b1, 1'b0, 1'b1);
    chk("t5_valid", ui_din_valid, 1'b0);
    chk("t5_drop", drop_count, 16'h0);
    repeat (3) idle(1'b0);
    chk("t5_no_resume", ui_din_valid, 1'b0);
    obs_q.delete();
    step(1'b1, rnd88(), 1'b1, 1'b0, 1'b0);
    drain();
    chk("t5_seq0", (obs_q.size() > 1) ? obs_q[1][15:8] : 16'hDEAD, 8'h00);

    // Test 6: disabled ingress, then enable toggling mid-frame
    for (int i = 0; i < 3; i++) begin
      step(1'b1, rnd88(), 1'b0, 1'b0, 1'b0);
      step(1'b0, 88'h0, 1'b0, 1'b0, 1'b0);
    end
    chk("t6_valid", ui_din_valid, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_drop", drop_count, 16'h0);
    obs_q.delete();
    d = rnd88();
    step(1'b1, d, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) step(i[0] ? 1'b0 : 1'b1, rnd88(), i[0], 1'b0, 1'b0);
    drain();
    chk("t6_count", obs_q.size(), 7);
    for (int k = 0; k < 7 && k < obs_q.size(); k++) chk("t6_word", obs_q[k], exp_word(8'd1, d, k));

    // Randomized traffic
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 3) == 0, rnd88(), $urandom_range(0, 15) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 999) == 0);
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
